// File: rtl/regfile_wb_pkg.sv
// Shared widths, constants, debug FSM encoding and the operand/debug read selector for regfile_wb.
// The selector honours the bypass flag that regfile_wb derives from REGFILE_BYPASS_EN.
package regfile_wb_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int RADDR_WIDTH = 5;
  localparam int NUM_REGS    = 32;

  localparam logic [RADDR_WIDTH-1:0] ZERO_REG      = 5'd0;
  localparam logic [DATA_WIDTH-1:0]  ZERO          = 32'd0;
  localparam logic                   WRITE_DISABLE = 1'b0;
  localparam logic                   WRITE_ENABLE  = 1'b1;

  typedef enum logic [1:0] {
    DBG_IDLE = 2'd0,
    DBG_READ = 2'd1,
    DBG_ACK  = 2'd2
  } dbg_state_e;

  // x0 is hard-wired to zero; a pending write-back wins over the array only when bypass is built in.
  function automatic logic [DATA_WIDTH-1:0] rf_read(
    input logic [RADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0]  arr_val,
    input logic                   bypass_en,
    input logic                   wb_we,
    input logic [RADDR_WIDTH-1:0] wb_waddr,
    input logic [DATA_WIDTH-1:0]  wb_wdata
  );
    logic [DATA_WIDTH-1:0] val;
    if (addr == ZERO_REG) begin
      val = ZERO;
    end else if (bypass_en && wb_we && (addr == wb_waddr)) begin
      val = wb_wdata;
    end else begin
      val = arr_val;
    end
    return val;
  endfunction

endpackage

// File: rtl/regfile_wb_dbg_port.sv
// Four-phase debug read port: IDLE latches the address, READ samples the register value, ACK holds it.
// The address is latched once per handshake so later dbg_addr_i changes have no effect.
module regfile_dbg_port
  import regfile_wb_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   dbg_req_i,
  input  logic [RADDR_WIDTH-1:0] dbg_addr_i,
  input  logic [DATA_WIDTH-1:0]  rd_data_i,
  output logic [RADDR_WIDTH-1:0] rd_addr_o,
  output logic                   dbg_ack_o,
  output logic [DATA_WIDTH-1:0]  dbg_data_o
);

  dbg_state_e             state_q, state_d;
  logic [RADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   ack_q, ack_d;

  // Handshake state and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= DBG_IDLE;
      addr_q  <= ZERO_REG;
      data_q  <= ZERO;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ack_d   = ack_q;
    case (state_q)
      DBG_IDLE: begin
        ack_d = 1'b0;
        if (dbg_req_i) begin
          addr_d  = dbg_addr_i;
          state_d = DBG_READ;
        end else begin
          state_d = DBG_IDLE;
        end
      end
      DBG_READ: begin
        data_d  = rd_data_i;
        ack_d   = 1'b1;
        state_d = DBG_ACK;
      end
      DBG_ACK: begin
        if (!dbg_req_i) begin
          ack_d   = 1'b0;
          state_d = DBG_IDLE;
        end else begin
          ack_d   = 1'b1;
          state_d = DBG_ACK;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = DBG_IDLE;
      end
    endcase
  end

  assign rd_addr_o  = addr_q;
  assign dbg_ack_o  = ack_q;
  assign dbg_data_o = data_q;

endmodule

// File: rtl/regfile_wb.sv
// 32x32 register file with a one-stage write-back register (2-edge write latency) and a debug read port.
// Define REGFILE_BYPASS_EN to forward the pending write-back value to operand and debug reads.
module regfile_wb
  import regfile_wb_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   reg_we_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic [DATA_WIDTH-1:0]  reg_wdata_i,
  input  logic [RADDR_WIDTH-1:0] reg1_raddr_i,
  input  logic [RADDR_WIDTH-1:0] reg2_raddr_i,
  output logic [DATA_WIDTH-1:0]  reg1_rdata_o,
  output logic [DATA_WIDTH-1:0]  reg2_rdata_o,
  input  logic                   dbg_req_i,
  input  logic [RADDR_WIDTH-1:0] dbg_addr_i,
  output logic                   dbg_ack_o,
  output logic [DATA_WIDTH-1:0]  dbg_data_o
);

`ifdef REGFILE_BYPASS_EN
  localparam logic BYPASS_EN = 1'b1;
`else
  localparam logic BYPASS_EN = 1'b0;
`endif

  logic [DATA_WIDTH-1:0]  regs_q [NUM_REGS];
  logic                   wb_we_q;
  logic [RADDR_WIDTH-1:0] wb_waddr_q;
  logic [DATA_WIDTH-1:0]  wb_wdata_q;

  logic [RADDR_WIDTH-1:0] dbg_raddr_s;
  logic [DATA_WIDTH-1:0]  dbg_rdata_s;

  // Capture into the write-back stage while committing the previously held entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= ZERO;
      end
      wb_we_q    <= WRITE_DISABLE;
      wb_waddr_q <= ZERO_REG;
      wb_wdata_q <= ZERO;
    end else begin
      wb_we_q    <= (reg_we_i && (reg_waddr_i != ZERO_REG)) ? WRITE_ENABLE : WRITE_DISABLE;
      wb_waddr_q <= reg_waddr_i;
      wb_wdata_q <= reg_wdata_i;
      if (wb_we_q) begin
        regs_q[wb_waddr_q] <= wb_wdata_q;
      end
    end
  end

  // Operand and debug read muxes; operands are forced to zero while reset is held.
  always_comb begin
    reg1_rdata_o = ZERO;
    reg2_rdata_o = ZERO;
    dbg_rdata_s  = rf_read(dbg_raddr_s, regs_q[dbg_raddr_s], BYPASS_EN,
                           wb_we_q, wb_waddr_q, wb_wdata_q);
    if (rst_i) begin
      reg1_rdata_o = ZERO;
      reg2_rdata_o = ZERO;
    end else begin
      reg1_rdata_o = rf_read(reg1_raddr_i, regs_q[reg1_raddr_i], BYPASS_EN,
                             wb_we_q, wb_waddr_q, wb_wdata_q);
      reg2_rdata_o = rf_read(reg2_raddr_i, regs_q[reg2_raddr_i], BYPASS_EN,
                             wb_we_q, wb_waddr_q, wb_wdata_q);
    end
  end

  regfile_dbg_port u_dbg_port (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .dbg_req_i  (dbg_req_i),
    .dbg_addr_i (dbg_addr_i),
    .rd_data_i  (dbg_rdata_s),
    .rd_addr_o  (dbg_raddr_s),
    .dbg_ack_o  (dbg_ack_o),
    .dbg_data_o (dbg_data_o)
  );

endmodule
